iq_demod_multi: RTL and testbench

//  Parametrised IQ demodulator: FM (cross-product discriminator) or AM (max+min/4 envelope, DC-tracked),

---
 rtl/iq_demod_pkg.sv | 33 +++
 rtl/iq_demod_multi_mult.sv | 22 ++
 rtl/iq_demod_multi.sv | 214 +++++++++++++++++++++
 tb/tb_iq_demod_multi.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/iq_demod_pkg.sv
// Shared constants and helpers for the IQ demodulator.
// Build option: IQ_DEMOD_DEEMPH_EN adds an FM de-emphasis stage (one extra cycle).
package iq_demod_pkg;

    localparam logic MODE_FM = 1'b0;
    localparam logic MODE_AM = 1'b1;

`ifdef IQ_DEMOD_DEEMPH_EN
    localparam int DEMOD_LAT = 4;
`else
    localparam int DEMOD_LAT = 3;
`endif

    // Wide enough for any pre-saturation value in the datapath.
    localparam int SAT_W = 40;

    // Clamp a signed value to the range of a signed 'width'-bit word.
    function automatic logic signed [SAT_W-1:0] sat_trunc(
        input logic signed [SAT_W-1:0] value,
        input int                      width
    );
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (SAT_W'(1) <<< (width - 1)) - SAT_W'(1);
        lo = -hi - SAT_W'(1);
        if (value > hi)
            return hi;
        else if (value < lo)
            return lo;
        return value;
    endfunction

endpackage

// File: rtl/iq_demod_multi_mult.sv
// Registered signed multiplier used for the FM cross products.
module iq_cross_mult
    import iq_demod_pkg::*;
#(
    parameter int DATA_W = 12
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic signed [DATA_W-1:0]   a,
    input  logic signed [DATA_W-1:0]   b,
    output logic signed [2*DATA_W-1:0] prod
);

    // One-cycle registered product; operands are sign-extended first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            prod <= '0;
        else
            prod <= (2*DATA_W)'(a) * (2*DATA_W)'(b);
    end

endmodule

// File: rtl/iq_demod_multi.sv
// IQ demodulator, FM cross-product discriminator or AM envelope with DC removal.
// Fixed latency DEMOD_LAT, saturating output, mode switch flushes history/DC.
// Build option: IQ_DEMOD_DEEMPH_EN inserts an FM de-emphasis IIR (AM delayed to match).
module iq_demod_multi
    import iq_demod_pkg::*;
#(
    parameter int DATA_W   = 12,
    parameter int OUT_W    = 12,
    parameter int FM_SHIFT = 10,
    parameter int DC_SHIFT = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] i_in,
    input  logic signed [DATA_W-1:0] q_in,
    input  logic                     mode,
    output logic                     out_valid,
    output logic signed [OUT_W-1:0]  demod_out,
    output logic                     sat
);

    localparam int P_W   = 2*DATA_W + 1;
    localparam int ACC_W = DATA_W + 3;
    localparam int M_W   = DATA_W + 2;

    logic signed [DATA_W-1:0]   i_prev, q_prev;
    logic                       mode_q;
    logic signed [ACC_W-1:0]    dc;
    logic                       mode_switch;
    logic signed [DATA_W:0]     i_ext, q_ext;
    logic        [DATA_W:0]     i_abs, q_abs, abs_max, abs_min;
    logic        [M_W-1:0]      mag;
    logic signed [ACC_W:0]      am_err;
    logic signed [ACC_W-1:0]    dc_sum;

    logic signed [2*DATA_W-1:0] prod_qi, prod_iq;

    logic                       v1, am1, flush1;
    logic signed [ACC_W:0]      am_diff1;

    logic signed [P_W-1:0]      fm_p, fm_r;
    logic                       v2, am2, flush2;
    logic signed [SAT_W-1:0]    val2;
    logic signed [SAT_W-1:0]    sat_val;

    logic                       v3, sat3;
    logic signed [OUT_W-1:0]    demod3;

    // Input-side envelope, DC error and mode-switch detection.
    always_comb begin
        mode_switch = in_valid && (mode != mode_q);
        i_ext   = (DATA_W+1)'(i_in);
        q_ext   = (DATA_W+1)'(q_in);
        i_abs   = i_ext[DATA_W] ? unsigned'(-i_ext) : unsigned'(i_ext);
        q_abs   = q_ext[DATA_W] ? unsigned'(-q_ext) : unsigned'(q_ext);
        abs_max = (i_abs >= q_abs) ? i_abs : q_abs;
        abs_min = (i_abs >= q_abs) ? q_abs : i_abs;
        mag     = {1'b0, abs_max} + M_W'(abs_min >> 2);
        am_err  = signed'({2'b00, mag}) - (ACC_W+1)'(dc);
        dc_sum  = dc + ACC_W'(am_err >>> DC_SHIFT);
    end

    // Sample history, stored mode and DC tracker advance only on valid samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_prev <= '0;
            q_prev <= '0;
            mode_q <= MODE_FM;
            dc     <= '0;
        end else if (in_valid) begin
            i_prev <= i_in;
            q_prev <= q_in;
            mode_q <= mode;
            if (mode_switch)
                dc <= '0;
            else if (mode == MODE_AM)
                dc <= dc_sum;
        end
    end

    iq_cross_mult #(.DATA_W(DATA_W)) u_mult_qi (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (q_in),
        .b     (i_prev),
        .prod  (prod_qi)
    );

    iq_cross_mult #(.DATA_W(DATA_W)) u_mult_iq (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (i_in),
        .b     (q_prev),
        .prod  (prod_iq)
    );

    // Stage 1: qualifiers and AM difference against the pre-update DC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1       <= 1'b0;
            am1      <= MODE_FM;
            flush1   <= 1'b0;
            am_diff1 <= '0;
        end else begin
            v1       <= in_valid;
            am1      <= mode;
            flush1   <= mode_switch;
            am_diff1 <= am_err;
        end
    end

    // Cross-product difference at full width, then scaled.
    always_comb begin
        fm_p = P_W'(prod_qi) - P_W'(prod_iq);
        fm_r = fm_p >>> FM_SHIFT;
    end

    // Stage 2: select the pre-saturation value for the sample's own mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2     <= 1'b0;
            am2    <= MODE_FM;
            flush2 <= 1'b0;
            val2   <= '0;
        end else begin
            v2     <= v1;
            am2    <= am1;
            flush2 <= flush1;
            val2   <= am1 ? SAT_W'(am_diff1) : SAT_W'(fm_r);
        end
    end

    // Saturation of the stage-2 value.
    always_comb begin
        sat_val = sat_trunc(val2, OUT_W);
    end

    // Stage 3: clamp, flag clipping, force mode-switch samples to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v3     <= 1'b0;
            demod3 <= '0;
            sat3   <= 1'b0;
        end else begin
            v3 <= v2;
            if (v2) begin
                demod3 <= flush2 ? '0 : sat_val[OUT_W-1:0];
                sat3   <= !flush2 && (sat_val != val2);
            end else begin
                sat3   <= 1'b0;
            end
        end
    end

`ifdef IQ_DEMOD_DEEMPH_EN
    localparam int Y_W = OUT_W + 3;

    // y carries 3 fractional bits so the filter settles exactly on a constant input.
    logic                    am3, flush3;
    logic                    v4, sat4;
    logic signed [OUT_W-1:0] demod4;
    logic signed [Y_W-1:0]   y, y_next;

    // Mode and flush tags follow the sample into the filter stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            am3    <= MODE_FM;
            flush3 <= 1'b0;
        end else begin
            am3    <= am2;
            flush3 <= flush2;
        end
    end

    // Scaled form of y += (x - y) >>> 3.
    always_comb begin
        y_next = y + Y_W'(demod3) - (y >>> 3);
    end

    // Stage 4: de-emphasis on FM, plain delay on AM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v4     <= 1'b0;
            sat4   <= 1'b0;
            demod4 <= '0;
            y      <= '0;
        end else begin
            v4   <= v3;
            sat4 <= v3 && sat3;
            if (v3) begin
                if (flush3) begin
                    y      <= '0;
                    demod4 <= '0;
                end else if (am3) begin
                    demod4 <= demod3;
                end else begin
                    y      <= y_next;
                    demod4 <= OUT_W'(y_next >>> 3);
                end
            end
        end
    end

    assign out_valid = v4;
    assign demod_out = demod4;
    assign sat       = sat4;
`else
    assign out_valid = v3;
    assign demod_out = demod3;
    assign sat       = sat3;
`endif

endmodule

// File: tb/tb_iq_demod_multi.sv
// Self-checking bench for iq_demod_multi with an arithmetic reference model.
module tb_iq_demod_multi;
    import iq_demod_pkg::*;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic signed [11:0] i_in = '0;
    logic signed [11:0] q_in = '0;
    logic               mode = 1'b0;
    logic               out_valid;
    logic signed [11:0] demod_out;
    logic               sat;

    iq_demod_multi dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .i_in      (i_in),
        .q_in      (q_in),
        .mode      (mode),
        .out_valid (out_valid),
        .demod_out (demod_out),
        .sat       (sat)
    );

    always #5 clk = ~clk;

    typedef struct { int val; bit s; int due; } exp_t;
    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    int   m_i = 0, m_q = 0, m_dc = 0, m_y = 0;
    bit   m_mode = 1'b0;

    int   obs_val[$];
    bit   obs_sat[$];
    int   obs_cyc[$];
    int   in_cyc[$];
    int   seq_ref[$];

    task automatic chk(input bit ok, input string name, input int act, input int exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int clamp12(input int x, output bit clipped);
        clipped = (x > 2047) || (x < -2048);
        if (x > 2047) return 2047;
        if (x < -2048) return -2048;
        return x;
    endfunction

    // Reference model: one entry per accepted sample, due DEMOD_LAT cycles later.
    always @(posedge clk) begin
        int  e, p, ai, aq, mx, mn, mag;
        bit  s;
        exp_t t;
        cyc++;
        if (!rst_n) begin
            m_i = 0; m_q = 0; m_dc = 0; m_y = 0; m_mode = 1'b0;
        end else if (in_valid) begin
            s = 1'b0;
            if (mode != m_mode) begin
                e = 0;
                m_dc = 0;
                m_y = 0;
                m_mode = mode;
            end else if (mode == 1'b0) begin
                p = int'(q_in) * m_i - int'(i_in) * m_q;
                e = clamp12(p >>> 10, s);
`ifdef IQ_DEMOD_DEEMPH_EN
                m_y = m_y + e - (m_y >>> 3);
                e = m_y >>> 3;
`endif
            end else begin
                ai  = (i_in < 0) ? -int'(i_in) : int'(i_in);
                aq  = (q_in < 0) ? -int'(q_in) : int'(q_in);
                mx  = (ai >= aq) ? ai : aq;
                mn  = (ai >= aq) ? aq : ai;
                mag = mx + mn / 4;
                e   = clamp12(mag - m_dc, s);
                m_dc = m_dc + ((mag - m_dc) >>> 5);
            end
            m_i = int'(i_in);
            m_q = int'(q_in);
            t.val = e; t.s = s; t.due = cyc + DEMOD_LAT - 1;
            exp_q.push_back(t);
            in_cyc.push_back(cyc);
        end
    end

    // Compare process: every cycle, valid timing; on strobes, value and clip flag.
    always @(negedge clk) begin
        exp_t t;
        bit   exp_v;
        if (!rst_n) begin
            exp_q.delete();
            chk(out_valid == 1'b0 && demod_out == 12'sd0 && sat == 1'b0,
                "reset_idle", int'(out_valid) + int'(demod_out) + int'(sat), 0);
        end else begin
            exp_v = (exp_q.size() > 0) && (exp_q[0].due == cyc);
            chk(out_valid == exp_v, "out_valid_timing", int'(out_valid), int'(exp_v));
            if (exp_v) begin
                t = exp_q.pop_front();
                chk(int'(demod_out) == t.val, "demod_out", int'(demod_out), t.val);
                chk(sat == t.s, "sat_flag", int'(sat), int'(t.s));
            end
            while (exp_q.size() > 0 && exp_q[0].due < cyc) void'(exp_q.pop_front());
            if (out_valid) begin
                obs_val.push_back(int'(demod_out));
                obs_sat.push_back(sat);
                obs_cyc.push_back(cyc);
            end
        end
    end

    task automatic drive(input bit v, input int i, input int q, input bit m);
        @(posedge clk);
        #1;
        in_valid = v;
        i_in = 12'(i);
        q_in = 12'(q);
        mode = m;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 0, 0, mode);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic clear_obs();
        obs_val.delete();
        obs_sat.delete();
        obs_cyc.delete();
        in_cyc.delete();
    endtask

    function automatic int rnd(input real x);
        return $rtoi(x >= 0.0 ? x + 0.5 : x - 0.5);
    endfunction

    task automatic tone(input int n, input real step, input int gap, input bit m);
        real ph;
        for (int k = 0; k < n; k++) begin
            ph = k * step;
            drive(1'b1, rnd(1000.0 * $cos(ph)), rnd(1000.0 * $sin(ph)), m);
            if (gap > 0) idle(gap);
        end
        idle(1);
    endtask

    localparam real PI16 = 3.14159265358979 / 16.0;

    initial begin
        int last;

        // Reset held with in_valid toggling: outputs stay at zero.
        for (int k = 0; k < 8; k++) drive(k[0], 500, -300, 1'b0);
        drive(1'b0, 0, 0, 1'b0);
        rst_n = 1'b1;
        clear_obs();
        drive(1'b1, 100, 50, 1'b0);
        idle(8);
        chk(obs_val.size() == 1, "first_sample_count", obs_val.size(), 1);
        if (obs_val.size() == 1 && in_cyc.size() == 1) begin
            chk(obs_cyc[0] - in_cyc[0] + 1 == DEMOD_LAT, "first_latency",
                obs_cyc[0] - in_cyc[0] + 1, DEMOD_LAT);
            chk(obs_val[0] == 0, "first_sample_zero", obs_val[0], 0);
        end

        // FM tone, positive then negative phase step.
        do_reset();
        clear_obs();
        tone(60, PI16, 0, 1'b0);
        idle(6);
        seq_ref = obs_val;
        chk(obs_val.size() == 60, "tone_pos_count", obs_val.size(), 60);
        last = obs_val[$];
        chk(last >= 189 && last <= 191, "tone_pos_level", last, 190);
        chk(obs_sat[$] == 1'b0, "tone_pos_sat", int'(obs_sat[$]), 0);
        clear_obs();
        tone(60, -PI16, 0, 1'b0);
        idle(6);
        last = obs_val[$];
        chk(last >= -192 && last <= -189, "tone_neg_level", last, -190);

`ifndef IQ_DEMOD_DEEMPH_EN
        // FM clipping both directions.
        do_reset();
        clear_obs();
        drive(1'b1, 2047, 0, 1'b0);
        drive(1'b1, 0, 2047, 1'b0);
        drive(1'b1, 2047, 0, 1'b0);
        idle(6);
        chk(obs_val[1] == 2047, "fm_clip_pos", obs_val[1], 2047);
        chk(obs_sat[1] == 1'b1, "fm_clip_pos_sat", int'(obs_sat[1]), 1);
        chk(obs_val[2] == -2048, "fm_clip_neg", obs_val[2], -2048);
        chk(obs_sat[2] == 1'b1, "fm_clip_neg_sat", int'(obs_sat[2]), 1);
`endif

        // AM constant -2048: switch sample, clipped first output, DC decay.
        clear_obs();
        for (int k = 0; k < 202; k++) drive(1'b1, -2048, 0, 1'b1);
        idle(6);
        chk(obs_val[0] == 0 && obs_sat[0] == 1'b0, "am_switch_zero", obs_val[0], 0);
        chk(obs_val[1] == 2047, "am_first_clip", obs_val[1], 2047);
        chk(obs_sat[1] == 1'b1, "am_first_sat", int'(obs_sat[1]), 1);
        last = obs_val[$];
        chk(last >= 0 && last < 32, "am_dc_settled", last, 0);

        // Gapped FM tone reproduces the back-to-back sequence with spacing 3.
        do_reset();
        clear_obs();
        tone(60, PI16, 2, 1'b0);
        idle(6);
        chk(obs_val.size() == seq_ref.size(), "gap_count", obs_val.size(), seq_ref.size());
        for (int k = 0; k < obs_val.size() && k < seq_ref.size(); k++)
            chk(obs_val[k] == seq_ref[k], "gap_seq", obs_val[k], seq_ref[k]);
        for (int k = 1; k < obs_cyc.size(); k++)
            chk(obs_cyc[k] - obs_cyc[k-1] == 3, "gap_spacing", obs_cyc[k] - obs_cyc[k-1], 3);

        // Mode switch FM -> AM -> FM mid-stream.
        do_reset();
        clear_obs();
        for (int k = 0; k < 10; k++)
            drive(1'b1, rnd(1000.0 * $cos(k * PI16)), rnd(1000.0 * $sin(k * PI16)), 1'b0);
        drive(1'b1, 300, 400, 1'b1);
        drive(1'b1, 300, 400, 1'b1);
        drive(1'b1, 300, 400, 1'b0);
        drive(1'b1, 300, 400, 1'b0);
        idle(6);
        chk(obs_val[10] == 0 && obs_sat[10] == 1'b0, "switch_to_am_zero", obs_val[10], 0);
        chk(obs_val[11] == 475, "am_after_switch", obs_val[11], 475);
        chk(obs_val[12] == 0, "switch_to_fm_zero", obs_val[12], 0);
        chk(obs_val[13] == 0, "fm_same_sample", obs_val[13], 0);

        // Reset mid-stream drops in-flight samples.
        clear_obs();
        drive(1'b1, 800, -600, 1'b0);
        drive(1'b1, -700, 500, 1'b0);
        #1;
        rst_n = 1'b0;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(8);
        chk(obs_val.size() == 0, "midstream_drop", obs_val.size(), 0);

        chk(exp_q.size() == 0, "model_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
